// File: rtl/tone_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tone_sequencer_pkg
// Purpose  : Shared register map, command bits, status layout and FSM states
//            for the tone sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package tone_sequencer_pkg;

   // Register byte addresses
   localparam logic [15:0] ADDR_NOTE = 16'h0000;
   localparam logic [15:0] ADDR_CMD  = 16'h0004;
   localparam logic [15:0] ADDR_CFG  = 16'h0008;

   // Command register bit indices
   localparam int CMD_START = 0;
   localparam int CMD_STOP  = 1;
   localparam int CMD_CLEAR = 2;

   // Status register bit positions
   localparam int ST_BUSY    = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_EMPTY   = 2;
   localparam int ST_OVF     = 3;
   localparam int ST_LEN_LSB = 8;
   localparam int ST_IDX_LSB = 16;

   // Sequencer states
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_PLAY = 2'd2,
      S_GAP  = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/tone_sequencer_ms_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : ms_tick_gen
// Purpose  : Free-running prescaler; one-cycle tick every CLOCK_FREQ_HZ/1000
//            clocks (one tick per millisecond).
// Revision : 1.0 - initial release
// ============================================================================
module ms_tick_gen #(
   parameter int CLOCK_FREQ_HZ = 20000000
) (
   input  logic clk,
   input  logic resetn,
   output logic tick
);
   // A divider below 2 would make the counter degenerate, so clamp it.
   localparam int DIV = ((CLOCK_FREQ_HZ / 1000) > 1) ? (CLOCK_FREQ_HZ / 1000) : 2;
   localparam int CW  = $clog2(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   // Wrap-around divider counter
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)          cnt <= '0;
      else if (cnt == LAST) cnt <= '0;
      else                  cnt <= cnt + CW'(1);
   end

   assign tick = (cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/tone_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tone_sequencer
// Purpose  : Bus-loaded note table played in order into the tone generator
//            period input, with optional inter-note gap and looping.
// Revision : 1.0 - initial release
// ============================================================================
module tone_sequencer
   import tone_sequencer_pkg::*;
#(
   parameter int CLOCK_FREQ_HZ = 20000000,
   parameter int DEPTH         = 16
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [3:0]  ctrl_wr,
   input  logic        ctrl_rd,
   input  logic [15:0] ctrl_addr,
   input  logic [31:0] ctrl_wdat,
   output logic [31:0] ctrl_rdat,
   output logic        ctrl_done,
   output logic [31:0] tone_period,
   output logic        tone_mute,
   output logic        busy,
   output logic        seq_done
);
   localparam int IW = $clog2(DEPTH);
   localparam int LW = IW + 1;
   localparam logic [LW-1:0] FULL_LEN = LW'(DEPTH);

   logic          tick;
   logic [31:0]   table_mem [DEPTH];
   logic [LW-1:0] length;
   logic [IW-1:0] index, index_nx, adv_index;
   logic [15:0]   gap_ms, ms_cnt, ms_cnt_nx, period_r;
   logic          loop_en, ovf, full;
   state_t        state, state_nx, adv_state;
   logic          adv_done, play_enter, mute_nx, seq_done_nx;
   logic          acc, wr_acc, rd_acc;
   logic          wr_note, wr_cfg, cmd_start, cmd_stop, cmd_clear;
   logic [31:0]   cur_entry, status, rd_mux;
   logic [15:0]   cur_period, cur_dur;

   ms_tick_gen #(.CLOCK_FREQ_HZ(CLOCK_FREQ_HZ)) u_tick (
      .clk    (clk),
      .resetn (resetn),
      .tick   (tick)
   );

   assign acc       = (|ctrl_wr || ctrl_rd) && !ctrl_done;
   assign wr_acc    = acc && |ctrl_wr;
   assign rd_acc    = acc && ctrl_rd;
   assign wr_note   = wr_acc && (ctrl_addr == ADDR_NOTE);
   assign wr_cfg    = wr_acc && (ctrl_addr == ADDR_CFG);
   assign cmd_clear = wr_acc && (ctrl_addr == ADDR_CMD) && ctrl_wdat[CMD_CLEAR];
   assign cmd_stop  = wr_acc && (ctrl_addr == ADDR_CMD) && ctrl_wdat[CMD_STOP];
   assign cmd_start = wr_acc && (ctrl_addr == ADDR_CMD) && ctrl_wdat[CMD_START];
   assign full      = (length == FULL_LEN);

   assign cur_entry   = table_mem[index];
   assign cur_period  = cur_entry[15:0];
   assign cur_dur     = cur_entry[31:16];
   assign tone_period = {16'b0, period_r};
   assign busy        = (state != S_IDLE);

   // Status word assembly
   always_comb begin
      status                     = '0;
      status[ST_BUSY]            = busy;
      status[ST_FULL]            = full;
      status[ST_EMPTY]           = (length == '0);
      status[ST_OVF]             = ovf;
      status[ST_LEN_LSB +: 5]    = 5'(length);
      status[ST_IDX_LSB +: 5]    = 5'(index);
   end

   // Read data multiplexer; unmapped or write-only addresses read as zero
   always_comb begin
      rd_mux = '0;
      if (ctrl_addr == ADDR_NOTE)     rd_mux = status;
      else if (ctrl_addr == ADDR_CFG) rd_mux = {15'b0, loop_en, gap_ms};
   end

   // Bus acknowledge and registered read data
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ctrl_done <= 1'b0;
         ctrl_rdat <= '0;
      end else begin
         ctrl_done <= acc;
         ctrl_rdat <= rd_acc ? rd_mux : '0;
      end
   end

   // Table fill level, overflow flag and playback configuration
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         length  <= '0;
         ovf     <= 1'b0;
         gap_ms  <= '0;
         loop_en <= 1'b0;
      end else begin
         if (cmd_clear) begin
            length <= '0;
            ovf    <= 1'b0;
         end else if (wr_note) begin
            if (full) ovf    <= 1'b1;
            else      length <= length + LW'(1);
         end
         if (wr_cfg) begin
            gap_ms  <= ctrl_wdat[15:0];
            loop_en <= ctrl_wdat[16];
         end
      end
   end

   // Note table storage; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (wr_note && !full) table_mem[length[IW-1:0]] <= ctrl_wdat;
   end

   // Where the sequence goes once the current note (and gap) is finished
   always_comb begin
      adv_state = S_IDLE;
      adv_index = index;
      adv_done  = 1'b0;
      if ((LW'(index) + LW'(1)) < length) begin
         adv_state = S_LOAD;
         adv_index = index + IW'(1);
      end else if (loop_en) begin
         adv_state = S_LOAD;
         adv_index = '0;
      end else begin
         adv_done = 1'b1;
      end
   end

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_nx;
   end

   // Next-state and datapath control; bus commands override note timing
   always_comb begin
      state_nx    = state;
      index_nx    = index;
      ms_cnt_nx   = ms_cnt;
      play_enter  = 1'b0;
      seq_done_nx = 1'b0;
      if (cmd_clear || cmd_stop) begin
         state_nx = S_IDLE;
         if (cmd_clear) index_nx = '0;
      end else if (cmd_start && (length != '0)) begin
         state_nx = S_LOAD;
         index_nx = '0;
      end else begin
         case (state)
            S_IDLE: state_nx = S_IDLE;
            S_LOAD: begin
               // Ticks are ignored here; zero-duration notes are skipped
               if (cur_dur == 16'd0) begin
                  state_nx    = adv_state;
                  index_nx    = adv_index;
                  seq_done_nx = adv_done;
               end else begin
                  state_nx   = S_PLAY;
                  ms_cnt_nx  = cur_dur;
                  play_enter = 1'b1;
               end
            end
            S_PLAY: begin
               if (tick) begin
                  if (ms_cnt <= 16'd1) begin
                     if (gap_ms != 16'd0) begin
                        state_nx  = S_GAP;
                        ms_cnt_nx = gap_ms;
                     end else begin
                        state_nx    = adv_state;
                        index_nx    = adv_index;
                        seq_done_nx = adv_done;
                     end
                  end else begin
                     ms_cnt_nx = ms_cnt - 16'd1;
                  end
               end
            end
            S_GAP: begin
               if (tick) begin
                  if (ms_cnt <= 16'd1) begin
                     state_nx    = adv_state;
                     index_nx    = adv_index;
                     seq_done_nx = adv_done;
                  end else begin
                     ms_cnt_nx = ms_cnt - 16'd1;
                  end
               end
            end
            default: state_nx = S_IDLE;
         endcase
      end
      // Mute follows the note on entry to PLAY, and is forced in IDLE/GAP;
      // LOAD holds the previous value so back-to-back notes do not click.
      mute_nx = tone_mute;
      if (play_enter)                                    mute_nx = (cur_period == 16'd0);
      else if ((state_nx == S_IDLE) || (state_nx == S_GAP)) mute_nx = 1'b1;
   end

   // Sequencer datapath registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         index     <= '0;
         ms_cnt    <= '0;
         period_r  <= '0;
         tone_mute <= 1'b1;
         seq_done  <= 1'b0;
      end else begin
         index     <= index_nx;
         ms_cnt    <= ms_cnt_nx;
         tone_mute <= mute_nx;
         seq_done  <= seq_done_nx;
         if (play_enter) period_r <= cur_period;
      end
   end

endmodule
`default_nettype wire

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
Bus-mapped note sequencer that drives the period input of the existing tone generator. Software loads a 16-entry note table over the icosoc ctrl bus. Each entry holds a period in µs and a duration in ms. On start, the block plays the table in order, optionally with an inter-note gap and endless looping, so the CPU does not have to time each note.

Parameters:
CLOCK_FREQ_HZ, 20000000, system clock frequency; one ms tick every CLOCK_FREQ_HZ/1000 cycles.
DEPTH, 16, note table entries; must be a power of 2.

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
ctrl_wr  in  4  byte write strobes; any bit set = write access
ctrl_rd  in  1  read access
ctrl_addr  in  16  register byte address
ctrl_wdat  in  32  write data
ctrl_rdat  out  32  read data, valid while ctrl_done=1
ctrl_done  out  1  one-cycle access acknowledge
tone_period  out  32  period in µs to tone generator; zero-extended from 16 bits
tone_mute  out  1  1 = silence tone output (rest, gap, idle)
busy  out  1  1 while sequencing
seq_done  out  1  one-cycle pulse when a non-loop sequence ends

Behaviour:
- Reset (async, resetn=0): ctrl_done=0, ctrl_rdat=0, tone_period=0, tone_mute=1, busy=0, seq_done=0. Also clears length, index, gap, loop, ovf and prescaler. Table RAM contents are not reset.
- Bus access timing:
  - Access is accepted when (|ctrl_wr or ctrl_rd) and !ctrl_done.
  - ctrl_done=1 the next cycle, for exactly one cycle.
  - Unmapped address: done still asserted, write ignored, rdat=0.
- Register map (byte address):
  - 0x00 W: append note. wdat[15:0] is the period in µs; wdat[31:16] is the duration in ms. Written at table[length], then length++. If length==DEPTH, the write is dropped and sticky ovf is set.
  - 0x04 W: command. bit0 start, bit1 stop, bit2 clear. Precedence: clear > stop > start.
  - 0x08 RW: bits[15:0] gap_ms; bit16 loop.
  - 0x00 R: status. [0] busy, [1] full (length==DEPTH), [2] empty, [3] ovf, [12:8] length, [20:16] current index.
- FSM states: IDLE, LOAD, PLAY, GAP.
  - IDLE: tone_mute=1. Start with length>0 → LOAD, index=0. Start with length==0 is ignored.
  - LOAD: one cycle. Reads table[index] and loads the ms counter with the duration.
    - Duration==0 skips the note: go directly to advance logic (1-cycle LOAD, no PLAY).
  - PLAY: tone_period=period. tone_mute=1 if period==0 (rest), else 0. The ms counter decrements on each tick; at 0 → GAP if gap_ms>0, else advance.
  - GAP: tone_mute=1 for gap_ms ticks, then advance.
  - Advance: index+1<length → LOAD with index+1. Otherwise, if loop → LOAD with index=0. Otherwise → IDLE and pulse seq_done.
- Prescaler is free-running from reset; tick is 1 cycle per ms. Note duration is accurate to within one tick (−1 ms, +0).
- Latency: a start write accepted at cycle N puts the FSM in LOAD at N+1. At N+2 the FSM is in PLAY, with tone_period and tone_mute updated.
- Stop while busy: → IDLE next cycle, tone_mute=1, no seq_done pulse. tone_period holds its last value.
- Start while busy: restart at index 0 via LOAD.
- Clear: stop as above; length=0, index=0, ovf=0.
- Appending while playing is allowed; the new note plays if it is reached before the end. Changing loop mid-sequence takes effect at the next advance.
- Simultaneous events:
  - A tick arriving in the same cycle as LOAD is not counted.
  - A bus command in the same cycle as the end-of-note advance: the command wins.

Decomposition:
- Shared package: register address constants (ADDR_NOTE, ADDR_CMD, ADDR_CFG), command bit indices, FSM state enum, status bit positions.
- One sub-module, ms_tick_gen: prescaler producing a 1-cycle tick every CLOCK_FREQ_HZ/1000 clocks, asynchronously reset.
- The table is a plain register array inside tone_sequencer.

Test Plan:
- CLOCK_FREQ_HZ=20000 (20 cycles/ms). Append {1136,3} and {0,2}, start → PLAY period=1136, mute=0 for 3 ms ±1 tick. Then rest with mute=1 for 2 ms, then IDLE with one seq_done pulse.
- Append 17 notes → status full=1, length=16, ovf=1. Clear → length=0, ovf=0, empty=1.
- gap_ms=1, two notes of 2 ms each → a mute=1 gap of 1 ms between notes and after the last note, then seq_done.
- loop=1 with 2 notes → index wraps 1→0 and no seq_done over 3 passes. Stop → mute=1 next cycle, busy=0.
- Duration=0 note between two notes → skipped, never drives tone_period. Start with empty table → stays IDLE.
- resetn pulsed low mid-PLAY → all outputs at reset values immediately; length=0 after release.
